// File: rtl/exe_branch_unit.sv
// Branch/JAL/JALR resolver: br_* registered one cycle after accept, link results queued for the CDB.
// Redirects never stall; issue backpressure comes only from the link FIFO (in_ready = count < DEPTH).
module exe_branch_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_inst,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [XLEN-1:0]  in_opr1,
  input  logic [XLEN-1:0]  in_opr2,
  input  logic [XLEN-1:0]  in_addr,
  output logic             br_valid,
  output logic [TAG_W-1:0] br_tag,
  output logic             br_taken,
  output logic [XLEN-1:0]  br_target,
  output logic             br_misalign,
  output logic             br_illegal,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] CLS_JALR   = 7'b1000000;
  localparam logic [6:0] CLS_JAL    = 7'b0100000;
  localparam logic [6:0] CLS_BRANCH = 7'b0000000;

  logic [6:0]      cls;
  logic [2:0]      funct3;
  logic            is_jalr, is_jal, is_branch, legal;
  logic            accept, push, pop;
  logic            cond_taken;
  logic [XLEN-1:0] sum;
  logic            res_taken;
  logic [XLEN-1:0] res_target;

  logic             br_valid_q, br_valid_d;
  logic [TAG_W-1:0] br_tag_q, br_tag_d;
  logic             br_taken_q, br_taken_d;
  logic [XLEN-1:0]  br_target_q, br_target_d;
  logic             br_misalign_q, br_misalign_d;
  logic             br_illegal_q, br_illegal_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];

  assign cls       = in_inst[9:3];
  assign funct3    = in_inst[2:0];
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign accept    = in_valid & in_ready & ~flush;
  assign cdb_valid = (count_q != '0);
  assign pop       = cdb_valid & cdb_grant;

  always_comb begin
    is_jalr    = (cls == CLS_JALR);
    is_jal     = (cls == CLS_JAL);
    is_branch  = (cls == CLS_BRANCH);
    sum        = in_opr1 + in_opr2;
    cond_taken = 1'b0;
    legal      = is_jalr | is_jal;
    case (funct3)
      3'b000:  cond_taken = (in_opr1 == in_opr2);
      3'b001:  cond_taken = (in_opr1 != in_opr2);
      3'b100:  cond_taken = ($signed(in_opr1) <  $signed(in_opr2));
      3'b101:  cond_taken = ($signed(in_opr1) >= $signed(in_opr2));
      3'b110:  cond_taken = (in_opr1 <  in_opr2);
      3'b111:  cond_taken = (in_opr1 >= in_opr2);
      default: cond_taken = 1'b0;
    endcase
    if (is_branch && funct3 != 3'b010 && funct3 != 3'b011) legal = 1'b1;

    res_taken  = 1'b0;
    res_target = '0;
    if (legal) begin
      if (is_jalr) begin
        res_taken  = 1'b1;
        res_target = {sum[XLEN-1:1], 1'b0};
      end else if (is_jal) begin
        res_taken  = 1'b1;
        res_target = sum;
      end else begin
        res_taken  = cond_taken;
        res_target = in_addr;
      end
    end
  end

  // Only legal jumps with a real destination produce a link writeback.
  assign push = accept & legal & (is_jal | is_jalr) & (in_tag != '0);

  always_comb begin
    br_valid_d    = 1'b0;
    br_tag_d      = '0;
    br_taken_d    = 1'b0;
    br_target_d   = '0;
    br_misalign_d = 1'b0;
    br_illegal_d  = 1'b0;
    if (accept) begin
      br_valid_d    = 1'b1;
      br_tag_d      = in_tag;
      br_taken_d    = res_taken;
      br_target_d   = res_target;
      br_misalign_d = res_taken & (res_target[1:0] != 2'b00);
      br_illegal_d  = ~legal;
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_valid_q    <= 1'b0;
      br_tag_q      <= '0;
      br_taken_q    <= 1'b0;
      br_target_q   <= '0;
      br_misalign_q <= 1'b0;
      br_illegal_q  <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      br_valid_q    <= br_valid_d;
      br_tag_q      <= br_tag_d;
      br_taken_q    <= br_taken_d;
      br_target_q   <= br_target_d;
      br_misalign_q <= br_misalign_d;
      br_illegal_q  <= br_illegal_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: reads are masked by cdb_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q]  <= in_tag;
      data_mem[wr_ptr_q] <= in_addr;
    end
  end

  assign br_valid    = br_valid_q;
  assign br_tag      = br_tag_q;
  assign br_taken    = br_taken_q;
  assign br_target   = br_target_q;
  assign br_misalign = br_misalign_q;
  assign br_illegal  = br_illegal_q;
  assign cdb_tag     = cdb_valid ? tag_mem[rd_ptr_q]  : '0;
  assign cdb_data    = cdb_valid ? data_mem[rd_ptr_q] : '0;

endmodule

// File: doc/exe_branch_unit.md
# exe_branch_unit

Parametrised, registered branch/jump execution unit for the out-of-order core. It accepts one issued branch/JAL/JALR per cycle from the reservation station and resolves it. It emits a registered redirect for the front end and ROB, plus the link value. Link results are buffered in a small FIFO so writeback survives CDB arbitration stalls. Resolution flags misaligned targets and illegal encodings, and the unit supports pipeline flush.

## Interface
- XLEN, 32, operand/address width
- TAG_W, 6, ROB tag width; tag 0 means "no destination"
- DEPTH, 4, CDB result FIFO depth (power of two, >= 2)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of all in-flight state
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept this cycle
- in_inst  in  10  [9:3] class (1000000 JALR, 0100000 JAL, 0000000 BRANCH), [2:0] funct3
- in_tag  in  TAG_W  ROB tag
- in_opr1, in_opr2  in  XLEN each  operands (JAL/JALR: target base/offset; BRANCH: compare values)
- in_addr  in  XLEN  JAL/JALR: link value (pc+4); BRANCH: taken target
- br_valid  out  1  redirect/resolution pulse
- br_tag  out  TAG_W  tag of resolved instruction
- br_taken  out  1  taken
- br_target  out  XLEN  resolved target
- br_misalign  out  1  taken and br_target[1:0] != 0
- br_illegal  out  1  undefined class or funct3
- cdb_valid  out  1  FIFO head valid
- cdb_grant  in  1  CDB arbiter grant
- cdb_tag  out  TAG_W  head tag
- cdb_data  out  XLEN  head link value

## Operation
- Accept when in_valid & in_ready & !flush. in_ready = (fifo_count < DEPTH), independent of instruction type.
- JALR: target = (opr1 + opr2) & ~1, taken = 1.
- JAL: target = opr1 + opr2, taken = 1.
- BRANCH: target = in_addr; taken is set by funct3:
  - 000 EQ, 001 NE.
  - 100 LT, 101 GE (signed XLEN).
  - 110 LTU, 111 GEU (unsigned).
- Additions are modulo 2^XLEN; carry is discarded.
- Illegal cases are BRANCH with funct3 010/011, or any other class. On an illegal case: br_valid=1, br_illegal=1, br_taken=0, br_target=0, and nothing is pushed.
- br_misalign = br_taken & (br_target[1:0] != 0). bit0 is always 0 for JALR.
- FIFO push: an accepted JAL/JALR with in_tag != 0 pushes {in_tag, in_addr}. BRANCH and tag-0 jumps never push.
- FIFO pop: cdb_valid & cdb_grant. cdb_tag/cdb_data show the head whenever cdb_valid=1.
  - Push and pop in the same cycle leave the count unchanged and keep order.
  - Pop on empty is ignored.
- Pointers wrap modulo DEPTH. The count is a separate $clog2(DEPTH)+1-bit register.
- flush clears the FIFO (count=0, pointers=0) and forces br_valid=0 next cycle. Any request presented in the flush cycle is dropped. A pop granted in the flush cycle is still consumed.

## Timing
- Reset (rst_n low, asynchronous): all outputs are 0, FIFO is empty, and in_ready=1 after reset.
- br_* outputs are registered. They are valid exactly one cycle after accept and are a one-cycle pulse, with no backpressure.
- br_* fields are held at 0 when br_valid=0.
- cdb_valid rises, at the earliest, one cycle after the accepting edge when the FIFO was empty. There is no combinational path from in_* to cdb_*.
- in_ready is a function of registered count only. If full, a pop in the same cycle does not raise in_ready until the next cycle.
- Back-to-back accepts are allowed at one per cycle while not full.
- When rst_n is asserted mid-operation, all state is discarded immediately.

## Test plan
- BEQ tag 5, opr1=opr2=0x10, addr=0x2000 -> next cycle br_valid=1, br_taken=1, br_target=0x2000, br_tag=5, cdb_valid stays 0.
- BLT opr1=0xFFFFFFFF, opr2=1 -> taken=1. BLTU with the same operands -> taken=0. BGEU with the same operands -> taken=1.
- JALR tag 3, opr1=0x1003, opr2=0, addr=0x404 -> br_target=0x1002, br_misalign=1. Then cdb_valid=1, cdb_tag=3, cdb_data=0x404.
- Issue 4 JALs (tags 1..4) with cdb_grant=0 -> in_ready=0 after the 4th. Then hold grant=1 -> tags pop in order 1,2,3,4, and in_ready rises the cycle after the first pop.
- FIFO holds 2 entries and flush is asserted together with a JAL request -> next cycle cdb_valid=0, br_valid=0, count=0, and the request is not accepted.
- BRANCH funct3=010 -> br_valid=1, br_illegal=1, br_taken=0, no push. Assert rst_n=0 mid-stream -> all outputs 0 immediately.
